mcmem_resp: RTL

- Word-addressed data/instruction memory responder for the multicycle CPU.
- Sits on the far side of the CPU memory port: the control unit drives address, write data and the write/read intent; this block answers after a programmable number of wait states.
- Replaces the zero-latency memory so the CPU FSM can be exercised with a ready-gated handshake.
- Holds DEPTH 32-bit words, detects misaligned or out-of-range accesses, and reports its FSM state for debug.

---
 rtl/mcmem_pkg.sv | 33 +++
 rtl/mcmem_ram.sv | 46 ++++
 rtl/mcmem_resp.sv | 114 +++++++++++
 3 files changed

// File: rtl/mcmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mcmem_pkg
// Brief    : Shared constants and types for the multicycle memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package mcmem_pkg;

    // Data word width of the memory port
    localparam int DW    = 32;

    // Width of the wait-state counter (WAIT range 0..15)
    localparam int CNT_W = 4;

    // Responder FSM encoding; 2'b11 is unused and recovers as IDLE
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_BUSY = 2'b01;
    localparam logic [1:0] S_RESP = 2'b10;

    // One captured CPU access
    typedef struct packed {
        logic          we;
        logic [31:0]   addr;
        logic [DW-1:0] din;
    } acc_t;

    // Reject misaligned byte addresses and any address beyond the array
    function automatic logic addr_bad(input logic [31:0] a, input int aw);
        return (a[1:0] != 2'b00) || ((a >> (aw + 2)) != 32'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mcmem_ram.sv
`default_nettype none
// ============================================================================
// Module   : mcmem_ram
// Brief    : DEPTH x 32 single-port RAM, synchronous write, registered read.
//            Contents are never reset; only the read register is.
// Revision : 1.0 - initial release
// ============================================================================
module mcmem_ram
    import mcmem_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_din,
    output logic [DW-1:0] o_dout
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_dout;

    // Write port: array contents survive reset
    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            r_mem[i_addr] <= i_din;
        end
    end

    // Read port: register updates only on an enabled read, holds otherwise
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_dout <= '0;
        end else if (i_en && !i_we) begin
            r_dout <= r_mem[i_addr];
        end
    end

    assign o_dout = r_dout;

endmodule
`default_nettype wire

// File: rtl/mcmem_resp.sv
`default_nettype none
// ============================================================================
// Module   : mcmem_resp
// Brief    : Word-addressed memory responder for the multicycle CPU. Accepts
//            a request, inserts WAIT wait states, then pulses ready for one
//            cycle with err flagging misaligned / out-of-range accesses.
// Revision : 1.0 - initial release
// ============================================================================
module mcmem_resp
    import mcmem_pkg::*;
#(
    parameter int AW   = 8,
    parameter int WAIT = 2
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          req,
    input  logic          we,
    input  logic [31:0]   addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          ready,
    output logic          err,
    output logic [1:0]    state
);

    // Counter preload: BUSY lasts WAIT cycles, so load WAIT-1
    localparam logic [CNT_W-1:0] C_CNT_LOAD = (WAIT == 0) ? '0 : CNT_W'(WAIT - 1);
    localparam logic             C_NO_WAIT  = (WAIT == 0);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    acc_t             r_acc;
    logic             r_err;

    logic             w_idle;
    logic             w_accept;
    logic             w_enter_resp;
    logic             w_bad;
    acc_t             w_cur;
    logic [1:0]       w_state_nxt;

    // The illegal encoding behaves exactly like IDLE
    assign w_idle   = (r_state != S_BUSY) && (r_state != S_RESP);
    assign w_accept = w_idle && req;

    // Access seen by the commit logic: live inputs on a zero-wait acceptance,
    // the captured copy when finishing from BUSY
    always_comb begin
        w_cur = r_acc;
        if (w_idle) begin
            w_cur.we   = we;
            w_cur.addr = addr;
            w_cur.din  = din;
        end
    end

    assign w_enter_resp = (w_accept && C_NO_WAIT) ||
                          ((r_state == S_BUSY) && (r_cnt == '0));
    assign w_bad        = addr_bad(w_cur.addr, AW);

    // Next-state selection
    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_BUSY:  w_state_nxt = (r_cnt == '0) ? S_RESP : S_BUSY;
            S_RESP:  w_state_nxt = S_IDLE;
            default: begin
                if (req) begin
                    w_state_nxt = C_NO_WAIT ? S_RESP : S_BUSY;
                end
            end
        endcase
    end

    // FSM, wait counter, capture registers and error flag
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Set only on the edge entering RESP; clears on the way out
            r_err   <= w_enter_resp && w_bad;
            if (w_accept) begin
                r_acc <= w_cur;
                r_cnt <= C_CNT_LOAD;
            end else if ((r_state == S_BUSY) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Memory commits on the edge entering RESP, skipped for rejected accesses
    mcmem_ram #(
        .AW (AW)
    ) u_ram (
        .clk    (clk),
        .clrn   (clrn),
        .i_en   (w_enter_resp && !w_bad),
        .i_we   (w_cur.we),
        .i_addr (w_cur.addr[AW+1:2]),
        .i_din  (w_cur.din),
        .o_dout (dout)
    );

    assign ready = (r_state == S_RESP);
    assign err   = r_err;
    assign state = r_state;

endmodule
`default_nettype wire
